// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared fetch-unit state encoding, fault constant and entry sizing
package if_fetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DROP  = 2'd2,
    FAULT = 2'd3
  } state_t;
  localparam logic [31:0] FAULT_INSTR = 32'h0000_0000;
  localparam int FAULT_W = 1;
  function automatic int entry_w(int aw, int dw);
    return aw + dw + FAULT_W;
  endfunction
endpackage

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, instr, fault} entries with flush clear
module fetch_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];
  // storage and pointers; clear drops every entry, push with pop keeps count
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC-driven instruction fetch over a handshaked memory into a decode buffer
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_fault,
  input  logic              id_ready
);
  localparam int W  = entry_w(ADDR_W, DATA_W);
  localparam int CW = $clog2(DEPTH + 1);
  state_t        state;
  logic          push, full, empty, issue_ok, aligned;
  logic [W-1:0]  din;
  logic [CW-1:0] count;
  assign aligned  = pc[1:0] == 2'b00;
  assign issue_ok = state == IDLE && !flush && !full;
  assign pc_en    = rst && state == REQ && imem_ack && !flush;
  assign push     = pc_en || (issue_ok && !aligned);
  assign din      = state == REQ ? {imem_addr, imem_rdata, 1'b0} : {pc, DATA_W'(FAULT_INSTR), 1'b1};
  assign if_valid = count != '0;
  fetch_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (!empty && id_ready),
    .din   (din),
    .dout  ({if_pc, if_instr, if_fault}),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // fetch sequencing: issue on free space, hold request until ack, discard after redirect, stall on misaligned pc
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        IDLE: if (issue_ok) begin
          state    <= aligned ? REQ : FAULT;
          imem_req <= aligned;
          if (aligned) imem_addr <= pc;
        end
        REQ: if (imem_ack || flush) begin
          state    <= imem_ack ? IDLE : DROP;
          imem_req <= !imem_ack;
        end
        DROP: if (imem_ack) begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
        FAULT: if (flush) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
